// File: rtl/udp_panel_burst_writer.sv
// -----------------------------------------------------------------------------
// udp_panel_burst_writer
//
// Purpose:
//   Turns the byte stream of a UDP payload into pixel writes for up to eight
//   panel channels. The upper byte of the destination port selects this
//   engine; the low NUM_CH bits of the port are the channel mask. Payload
//   byte 0 is an opcode:
//     0x01 addressed : repeating {address, pixel} records
//     0x02 burst     : base address, then pixels at consecutive addresses
//     0x03 commit    : one-cycle ctrl_swap pulse on the masked channels
//   Multi-byte fields are big-endian. Corrupt beats, unknown opcodes and runt
//   records are counted in err_count. Good packets are counted in pkt_count
//   and toggle led_reg.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   udp_source_*            payload stream from the UDP core (byte in [7:0])
//   ctrl_en/addr/wdat       registered write request, held until ctrl_ready
//   ctrl_ready              write port accepts while ctrl_en != 0
//   ctrl_swap               one-cycle frame-commit pulse per channel
//   pkt_count, err_count    saturating good / bad packet counters
//   led_reg                 toggles on every good packet
// -----------------------------------------------------------------------------
module udp_panel_burst_writer #(
    parameter logic [7:0] PORT_MSB  = 8'h66,
    parameter int         NUM_CH    = 6,
    parameter int         ADDR_W    = 16,
    parameter int         PIX_BYTES = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   udp_source_valid,
    input  logic                   udp_source_last,
    output logic                   udp_source_ready,
    input  logic [15:0]            udp_source_dst_port,
    input  logic [31:0]            udp_source_data,
    input  logic [3:0]             udp_source_error,
    output logic [NUM_CH-1:0]      ctrl_en,
    output logic [ADDR_W-1:0]      ctrl_addr,
    output logic [8*PIX_BYTES-1:0] ctrl_wdat,
    input  logic                   ctrl_ready,
    output logic [NUM_CH-1:0]      ctrl_swap,
    output logic [15:0]            pkt_count,
    output logic [15:0]            err_count,
    output logic                   led_reg
);

    localparam int         ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int         WDAT_W     = 8 * PIX_BYTES;
    localparam logic [1:0] ADDR_LAST  = 2'(ADDR_BYTES - 1);
    localparam logic [1:0] PIX_LAST   = 2'(PIX_BYTES - 1);

    localparam logic [7:0] OP_ADDRESSED = 8'h01;
    localparam logic [7:0] OP_BURST     = 8'h02;
    localparam logic [7:0] OP_COMMIT    = 8'h03;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_PIX,
        S_DRAIN
    } state_t;

    state_t              r_state;
    logic                r_reset_d;
    logic                r_burst;
    logic                r_drain_good;   // draining the tail of a commit packet
    logic [1:0]          r_cnt;          // byte index inside the current field
    logic [NUM_CH-1:0]   r_mask;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_addr_sh;      // previous address byte
    logic [15:0]         r_pix_sh;       // previous two pixel bytes
    logic [NUM_CH-1:0]   r_ctrl_en;
    logic [ADDR_W-1:0]   r_ctrl_addr;
    logic [WDAT_W-1:0]   r_ctrl_wdat;
    logic [NUM_CH-1:0]   r_swap;
    logic [15:0]         r_pkt_count;
    logic [15:0]         r_err_count;
    logic                r_led;

    logic                w_pend;
    logic                w_beat;
    logic                w_err;
    logic [7:0]          w_byte;
    logic [15:0]         w_addr_word;
    logic [23:0]         w_pix_word;
    logic                w_unused_bits;

    assign w_pend = |r_ctrl_en;
    // NOTE: ready is combinational so a write completing and the next byte
    // being accepted can share a cycle; a registered ready would halve the
    // single-byte-pixel burst rate.
    assign udp_source_ready = !reset && !r_reset_d && !(w_pend && !ctrl_ready);
    assign w_beat = udp_source_valid && udp_source_ready;
    assign w_err  = |udp_source_error;
    assign w_byte = udp_source_data[7:0];

    // Fields are at most two address / three pixel bytes, so the current byte
    // plus the held history forms the whole field; only the low bits are kept.
    assign w_addr_word = {r_addr_sh, w_byte};
    assign w_pix_word  = {r_pix_sh, w_byte};

    // Only the low payload byte carries data.
    assign w_unused_bits = ^{udp_source_data[31:8], udp_source_dst_port};

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples values from before the edge; within this block a later
    // assignment to the same register in the same cycle takes precedence.
    always_ff @(posedge clock) begin
        r_reset_d <= reset;
        if (reset) begin
            r_state      <= S_IDLE;
            r_burst      <= 1'b0;
            r_drain_good <= 1'b0;
            r_cnt        <= '0;
            r_mask       <= '0;
            r_addr       <= '0;
            r_addr_sh    <= '0;
            r_pix_sh     <= '0;
            r_ctrl_en    <= '0;
            r_ctrl_addr  <= '0;
            r_ctrl_wdat  <= '0;
            r_swap       <= '0;
            r_pkt_count  <= '0;
            r_err_count  <= '0;
            r_led        <= 1'b0;
        end else begin
            r_swap <= '0;
            if (w_pend && ctrl_ready) begin
                r_ctrl_en <= '0;
            end
            if (w_beat) begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt        <= '0;
                        r_drain_good <= 1'b0;
                        if (udp_source_dst_port[15:8] != PORT_MSB) begin
                            // Not addressed to this engine: swallow silently.
                            if (!udp_source_last) r_state <= S_DRAIN;
                        end else if (w_err) begin
                            r_err_count <= sat_inc(r_err_count);
                            if (!udp_source_last) r_state <= S_DRAIN;
                        end else begin
                            case (w_byte)
                                OP_ADDRESSED, OP_BURST: begin
                                    r_burst <= (w_byte == OP_BURST);
                                    r_mask  <= udp_source_dst_port[NUM_CH-1:0];
                                    if (udp_source_last) begin
                                        r_pkt_count <= sat_inc(r_pkt_count);
                                        r_led       <= !r_led;
                                    end else begin
                                        r_state <= S_ADDR;
                                    end
                                end
                                OP_COMMIT: begin
                                    r_swap <= udp_source_dst_port[NUM_CH-1:0];
                                    if (udp_source_last) begin
                                        r_pkt_count <= sat_inc(r_pkt_count);
                                        r_led       <= !r_led;
                                    end else begin
                                        r_drain_good <= 1'b1;
                                        r_state      <= S_DRAIN;
                                    end
                                end
                                default: begin
                                    r_err_count <= sat_inc(r_err_count);
                                    if (!udp_source_last) r_state <= S_DRAIN;
                                end
                            endcase
                        end
                    end

                    S_ADDR: begin
                        if (w_err) begin
                            r_err_count <= sat_inc(r_err_count);
                            r_state     <= udp_source_last ? S_IDLE : S_DRAIN;
                        end else begin
                            r_addr_sh <= w_byte;
                            if (r_cnt == ADDR_LAST) begin
                                r_addr <= w_addr_word[ADDR_W-1:0];
                                r_cnt  <= '0;
                                if (!udp_source_last) begin
                                    r_state <= S_PIX;
                                end else begin
                                    // A burst base with no pixels ends on a
                                    // record boundary; an address without
                                    // its pixel is a runt.
                                    r_state <= S_IDLE;
                                    if (r_burst) begin
                                        r_pkt_count <= sat_inc(r_pkt_count);
                                        r_led       <= !r_led;
                                    end else begin
                                        r_err_count <= sat_inc(r_err_count);
                                    end
                                end
                            end else begin
                                r_cnt <= r_cnt + 2'd1;
                                if (udp_source_last) begin
                                    r_state     <= S_IDLE;
                                    r_err_count <= sat_inc(r_err_count);
                                end
                            end
                        end
                    end

                    S_PIX: begin
                        if (w_err) begin
                            r_err_count <= sat_inc(r_err_count);
                            r_state     <= udp_source_last ? S_IDLE : S_DRAIN;
                        end else begin
                            r_pix_sh <= w_pix_word[15:0];
                            if (r_cnt == PIX_LAST) begin
                                r_cnt <= '0;
                                if (r_mask != '0) begin
                                    r_ctrl_en   <= r_mask;
                                    r_ctrl_addr <= r_addr;
                                    r_ctrl_wdat <= w_pix_word[WDAT_W-1:0];
                                end
                                if (r_burst) begin
                                    r_addr <= r_addr + ADDR_W'(1);
                                end
                                if (udp_source_last) begin
                                    r_state     <= S_IDLE;
                                    r_pkt_count <= sat_inc(r_pkt_count);
                                    r_led       <= !r_led;
                                end else begin
                                    r_state <= r_burst ? S_PIX : S_ADDR;
                                end
                            end else begin
                                r_cnt <= r_cnt + 2'd1;
                                if (udp_source_last) begin
                                    r_state     <= S_IDLE;
                                    r_err_count <= sat_inc(r_err_count);
                                end
                            end
                        end
                    end

                    default: begin  // S_DRAIN
                        if (w_err) begin
                            // A corrupt commit tail turns the packet bad once.
                            if (r_drain_good) begin
                                r_err_count  <= sat_inc(r_err_count);
                                r_drain_good <= 1'b0;
                            end
                        end else if (udp_source_last && r_drain_good) begin
                            r_pkt_count <= sat_inc(r_pkt_count);
                            r_led       <= !r_led;
                        end
                        if (udp_source_last) r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ctrl_en   = r_ctrl_en;
    assign ctrl_addr = r_ctrl_addr;
    assign ctrl_wdat = r_ctrl_wdat;
    assign ctrl_swap = r_swap;
    assign pkt_count = r_pkt_count;
    assign err_count = r_err_count;
    assign led_reg   = r_led;

endmodule

// File: tb/tb_udp_panel_burst_writer.sv
// -----------------------------------------------------------------------------
// tb_udp_panel_burst_writer
//
// Purpose:
//   Directed bench for udp_panel_burst_writer. u_dut uses the default
//   parameters; u_dut1 uses single-byte pixels and a 10-bit address to cover
//   full-rate bursts, back-pressure and address truncation/wrap. Expected
//   writes are queued when packets are sent and popped as writes complete.
// -----------------------------------------------------------------------------
module tb_udp_panel_burst_writer;

    logic        clock;
    logic        reset;
    logic        udp_source_valid;
    logic        udp_source_valid1;
    logic        udp_source_last;
    logic [15:0] udp_source_dst_port;
    logic [31:0] udp_source_data;
    logic [3:0]  udp_source_error;

    logic        udp_source_ready;
    logic [5:0]  ctrl_en;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_wdat;
    logic        ctrl_ready;
    logic [5:0]  ctrl_swap;
    logic [15:0] pkt_count;
    logic [15:0] err_count;
    logic        led_reg;

    logic        udp_source_ready1;
    logic [5:0]  ctrl_en1;
    logic [9:0]  ctrl_addr1;
    logic [7:0]  ctrl_wdat1;
    logic        ctrl_ready1;
    logic [5:0]  ctrl_swap1;
    logic [15:0] pkt_count1;
    logic [15:0] err_count1;
    logic        led_reg1;

    int n_cmp = 0;
    int n_err = 0;
    int writes0 = 0;
    int writes1 = 0;
    int stalls1 = 0;
    int swap_cycles = 0;
    logic [5:0] swap_val = '0;

    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];

    udp_panel_burst_writer u_dut (
        .clock               (clock),
        .reset               (reset),
        .udp_source_valid    (udp_source_valid),
        .udp_source_last     (udp_source_last),
        .udp_source_ready    (udp_source_ready),
        .udp_source_dst_port (udp_source_dst_port),
        .udp_source_data     (udp_source_data),
        .udp_source_error    (udp_source_error),
        .ctrl_en             (ctrl_en),
        .ctrl_addr           (ctrl_addr),
        .ctrl_wdat           (ctrl_wdat),
        .ctrl_ready          (ctrl_ready),
        .ctrl_swap           (ctrl_swap),
        .pkt_count           (pkt_count),
        .err_count           (err_count),
        .led_reg             (led_reg)
    );

    udp_panel_burst_writer #(
        .PORT_MSB  (8'h66),
        .NUM_CH    (6),
        .ADDR_W    (10),
        .PIX_BYTES (1)
    ) u_dut1 (
        .clock               (clock),
        .reset               (reset),
        .udp_source_valid    (udp_source_valid1),
        .udp_source_last     (udp_source_last),
        .udp_source_ready    (udp_source_ready1),
        .udp_source_dst_port (udp_source_dst_port),
        .udp_source_data     (udp_source_data),
        .udp_source_error    (udp_source_error),
        .ctrl_en             (ctrl_en1),
        .ctrl_addr           (ctrl_addr1),
        .ctrl_wdat           (ctrl_wdat1),
        .ctrl_ready          (ctrl_ready1),
        .ctrl_swap           (ctrl_swap1),
        .pkt_count           (pkt_count1),
        .err_count           (err_count1),
        .led_reg             (led_reg1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Completed writes are compared against the scoreboard in issue order.
    always @(negedge clock) begin
        if (!reset && ctrl_en != '0 && ctrl_ready) begin
            writes0++;
            if (exp_q0.size() == 0) check("unexpected_write0", {ctrl_en, ctrl_addr, ctrl_wdat}, 64'h0);
            else check("write0", {ctrl_en, ctrl_addr, ctrl_wdat}, exp_q0.pop_front());
        end
        if (!reset && ctrl_en1 != '0 && ctrl_ready1) begin
            writes1++;
            if (exp_q1.size() == 0) check("unexpected_write1", {ctrl_en1, ctrl_addr1, ctrl_wdat1}, 64'h0);
            else check("write1", {ctrl_en1, ctrl_addr1, ctrl_wdat1}, exp_q1.pop_front());
        end
        if (udp_source_valid1 && !udp_source_ready1) stalls1++;
        if (ctrl_swap != '0) begin
            swap_cycles++;
            swap_val = ctrl_swap;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One beat, held until the selected DUT shows ready mid-cycle.
    task automatic send_beat(input int dut, input logic [7:0] b, input logic last, input logic [3:0] err);
        int waited;
        waited = 0;
        udp_source_data  = {24'h5A5A5A, b};
        udp_source_last  = last;
        udp_source_error = err;
        if (dut == 0) udp_source_valid = 1'b1;
        else udp_source_valid1 = 1'b1;
        @(negedge clock);
        while (!((dut == 0) ? udp_source_ready : udp_source_ready1) && waited < 100) begin
            waited++;
            @(negedge clock);
        end
        if (waited >= 100) check("ready_timeout", 64'(waited), 64'h0);
        @(posedge clock);
        #1;
        udp_source_valid  = 1'b0;
        udp_source_valid1 = 1'b0;
        udp_source_last   = 1'b0;
        udp_source_error  = 4'h0;
    endtask

    // bytes holds the packet right-aligned, first byte most significant.
    task automatic send_pkt(input int dut, input logic [15:0] port, input int n,
                            input logic [127:0] bytes, input int err_idx);
        udp_source_dst_port = port;
        for (int i = 0; i < n; i++) begin
            send_beat(dut, bytes[8*(n-1-i) +: 8], (i == n - 1), (i == err_idx) ? 4'h1 : 4'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        udp_source_valid    = 1'b0;
        udp_source_valid1   = 1'b0;
        udp_source_last     = 1'b0;
        udp_source_dst_port = '0;
        udp_source_data     = '0;
        udp_source_error    = '0;
        ctrl_ready          = 1'b1;
        ctrl_ready1         = 1'b1;

        // Reset state
        @(negedge clock);
        check("ready_in_reset", udp_source_ready, 0);
        idle(3);
        reset = 1'b0;
        check("rst_en", ctrl_en, 0);
        check("rst_swap", ctrl_swap, 0);
        check("rst_pkt", pkt_count, 0);
        check("rst_err", err_count, 0);
        check("rst_led", led_reg, 0);

        // Addressed write
        exp_q0.push_back({6'b000101, 16'h1234, 24'hAABBCC});
        send_pkt(0, 16'h6605, 6, 128'h01_1234_AABBCC, -1);
        idle(2);
        check("addr_pkt", pkt_count, 1);
        check("addr_led", led_reg, 1);
        check("addr_err", err_count, 0);
        check("addr_q", exp_q0.size(), 0);

        // Burst with address wrap
        exp_q0.push_back({6'b111111, 16'hFFFF, 24'h010203});
        exp_q0.push_back({6'b111111, 16'h0000, 24'h040506});
        send_pkt(0, 16'h663F, 9, 128'h02_FFFF_010203_040506, -1);
        idle(2);
        check("burst_pkt", pkt_count, 2);
        check("burst_led", led_reg, 0);
        check("burst_q", exp_q0.size(), 0);

        // Zero mask: parsed and counted, no write
        send_pkt(0, 16'h6640, 6, 128'h01_0001_112233, -1);
        idle(2);
        check("zmask_pkt", pkt_count, 3);
        check("zmask_led", led_reg, 1);
        check("zmask_writes", writes0, 3);

        // Foreign port: ignored entirely
        send_pkt(0, 16'h6505, 6, 128'h01_1234_AABBCC, -1);
        idle(2);
        check("port_pkt", pkt_count, 3);
        check("port_err", err_count, 0);
        check("port_writes", writes0, 3);

        // Commit on a foreign port: nothing
        swap_cycles = 0;
        send_pkt(0, 16'h6503, 1, 128'h03, -1);
        idle(3);
        check("commit_bad_port_swaps", swap_cycles, 0);
        check("commit_bad_port_pkt", pkt_count, 3);
        check("commit_bad_port_err", err_count, 0);

        // Commit: one-cycle swap pulse, trailing bytes ignored
        send_pkt(0, 16'h6603, 1, 128'h03, -1);
        idle(3);
        check("commit_swaps", swap_cycles, 1);
        check("commit_swap_val", swap_val, 6'b000011);
        swap_cycles = 0;
        send_pkt(0, 16'h6603, 3, 128'h03_AABB, -1);
        idle(3);
        check("commit2_swaps", swap_cycles, 1);
        check("commit_err", err_count, 0);
        check("commit_writes", writes0, 3);

        // Runt record
        send_pkt(0, 16'h6605, 4, 128'h01_1234_AA, -1);
        idle(2);
        check("runt_err", err_count, 1);
        check("runt_writes", writes0, 3);

        // Corrupt beat mid-packet
        send_pkt(0, 16'h6605, 6, 128'h01_1234_AABBCC, 3);
        idle(2);
        check("corrupt_err", err_count, 2);
        check("corrupt_writes", writes0, 3);

        // Unknown opcode
        send_pkt(0, 16'h6601, 3, 128'h07_AABB, -1);
        idle(2);
        check("badop_err", err_count, 3);

        // Single-byte pixels at full rate, 10-bit address
        stalls1 = 0;
        for (int i = 0; i < 4; i++) exp_q1.push_back({6'b000010, 10'(16 + i), 8'(8'hA0 + i)});
        send_pkt(1, 16'h6602, 7, 128'h02_0010_A0A1A2A3, -1);
        idle(2);
        check("rate_stalls", stalls1, 0);
        check("rate_writes", writes1, 4);

        // Back-pressure during a wrapping burst (base truncated to 0x3FE)
        exp_q1.push_back({6'b000001, 10'h3FE, 8'h11});
        exp_q1.push_back({6'b000001, 10'h3FF, 8'h22});
        exp_q1.push_back({6'b000001, 10'h000, 8'h33});
        exp_q1.push_back({6'b000001, 10'h001, 8'h44});
        exp_q1.push_back({6'b000001, 10'h002, 8'h55});
        exp_q1.push_back({6'b000001, 10'h003, 8'h66});
        fork
            send_pkt(1, 16'h6601, 9, 128'h02_FFFE_112233445566, -1);
            begin
                int polls;
                polls = 0;
                do begin
                    @(posedge clock);
                    #1;
                    polls++;
                end while (!(ctrl_en1 != '0 && ctrl_addr1 == 10'h000) && polls < 60);
                if (polls >= 60) check("bp_trigger_timeout", 64'(polls), 64'h0);
                ctrl_ready1 = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clock);
                    check("bp_hold_en", ctrl_en1, 6'b000001);
                    check("bp_hold_addr", ctrl_addr1, 10'h000);
                    check("bp_hold_wdat", ctrl_wdat1, 8'h33);
                    check("bp_ready_low", udp_source_ready1, 0);
                end
                @(posedge clock);
                #1;
                ctrl_ready1 = 1'b1;
            end
        join
        idle(3);
        check("bp_writes", writes1, 10);
        check("bp_q", exp_q1.size(), 0);
        check("bp_pkt", pkt_count1, 2);

        // Reset with a write pending under back-pressure
        ctrl_ready = 1'b0;
        send_pkt(0, 16'h6605, 6, 128'h01_0005_A1A2A3, -1);
        idle(2);
        check("pend_en", ctrl_en, 6'b000101);
        check("pend_addr", ctrl_addr, 16'h0005);
        check("pend_wdat", ctrl_wdat, 24'hA1A2A3);
        check("pend_ready", udp_source_ready, 0);
        reset = 1'b1;
        idle(1);
        check("rst2_en", ctrl_en, 0);
        check("rst2_pkt", pkt_count, 0);
        check("rst2_err", err_count, 0);
        check("rst2_led", led_reg, 0);
        reset = 1'b0;
        ctrl_ready = 1'b1;

        // Normal decode after reset
        exp_q0.push_back({6'b000111, 16'h0007, 24'h0A0B0C});
        send_pkt(0, 16'h6607, 6, 128'h01_0007_0A0B0C, -1);
        idle(3);
        check("post_pkt", pkt_count, 1);
        check("post_err", err_count, 0);
        check("post_led", led_reg, 1);
        check("post_q", exp_q0.size(), 0);
        check("post_writes", writes0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/udp_panel_burst_writer.md
# udp_panel_burst_writer

Parametrised UDP-to-panel write engine: consumes the byte stream of a UDP payload from the Ethernet core, decodes a small command protocol (addressed writes, auto-incrementing burst writes, frame commit) and issues pixel writes to up to 8 panel channels with a valid/ready back-pressured write port. Sits between the UDP core source port and the per-channel panel frame buffers.

## Interface
- PORT_MSB, 8'h66: required value of udp_source_dst_port[15:8]
- NUM_CH, 6: channel count (1..8); channel mask = udp_source_dst_port[NUM_CH-1:0]
- ADDR_W, 16: pixel address width (1..16); ADDR_BYTES = ceil(ADDR_W/8)
- PIX_BYTES, 3: bytes per pixel (1..3); WDAT_W = 8*PIX_BYTES

- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- udp_source_valid  in  1  payload beat valid
- udp_source_last  in  1  final beat of packet
- udp_source_ready  out  1  beat accepted when valid && ready
- udp_source_dst_port  in  16  destination port, stable for whole packet
- udp_source_data  in  32  payload; only [7:0] used, one byte per beat
- udp_source_error  in  4  nonzero = corrupt beat
- ctrl_en  out  NUM_CH  write request, one-hot/multi-hot channel mask
- ctrl_addr  out  ADDR_W  write address
- ctrl_wdat  out  WDAT_W  write data, first received byte in MSBs
- ctrl_ready  in  1  write port accepts when ctrl_en != 0 && ctrl_ready
- ctrl_swap  out  NUM_CH  one-cycle frame-commit pulse per channel
- pkt_count  out  16  packets completed without error, saturating
- err_count  out  16  errored/bad packets, saturating
- led_reg  out  1  toggles on every counted good packet

## Operation
- Beat = cycle with udp_source_valid && udp_source_ready. Only beats advance state.
- Byte 0 = opcode. 0x01 ADDRESSED: repeating records {ADDR_BYTES addr, PIX_BYTES pixel}. 0x02 BURST: ADDR_BYTES base address, then pixels; address +1 per pixel, wraps mod 2^ADDR_W. 0x03 COMMIT: pulse ctrl_swap = channel mask; remaining bytes ignored.
- Multi-byte fields big-endian; address upper bits beyond ADDR_W discarded.
- States: IDLE (expect opcode), ADDR, PIX, DRAIN (discard until last beat).
- IDLE: port mismatch -> DRAIN (no count). Opcode 0x01/0x02 -> ADDR, latch mask. 0x03 -> DRAIN (or stay IDLE if last). Other opcode -> DRAIN, err_count+1.
- ADDR complete -> PIX. PIX complete -> issue write; ADDRESSED -> ADDR, BURST -> PIX.
- Last beat while in IDLE-after-opcode/ADDR/PIX at record boundary -> IDLE, pkt_count+1, led toggles. Last beat mid-record (runt) -> partial record discarded, IDLE, err_count+1.
- Any beat with udp_source_error != 0: beat discarded, err_count+1, -> DRAIN (IDLE if last); writes already issued stand, pending write still completes.
- Packet of opcode only (last on byte 0, opcode 0x01/0x02) counts good, no writes.
- Mask of zero: fields parsed, no writes issued, packet counted good.

## Timing
- Reset: udp_source_ready 0 during reset, all other outputs 0, state IDLE, pending write dropped, counters 0. Reset mid-packet: remaining beats of that packet parsed as a new packet from IDLE.
- udp_source_ready = !reset_r && !(ctrl_en != 0 && !ctrl_ready) (combinational from registered pending flag and ctrl_ready).
- Write latency: ctrl_en/addr/wdat registered, asserted the cycle after the last pixel byte beat; held stable until ctrl_ready sampled high.
- Write completing and next byte beat in the same cycle allowed; PIX_BYTES=1 burst sustains one write per clock with ctrl_ready high.
- ctrl_swap asserted exactly one cycle, the cycle after the opcode beat.
- Counters and led_reg update the cycle after the terminating beat.

## Test plan
- ADDRESSED, port 0x6605, bytes 01 12 34 AA BB CC (last) -> one write ctrl_en=6'b000101, addr 0x1234, wdat 0xAABBCC; pkt_count=1, led_reg=1.
- BURST, port 0x663F, 02 FF FF then 2 pixels 010203 040506 -> writes addr 0xFFFF wdat 0x010203, then addr 0x0000 wdat 0x040506 (wrap).
- Back-pressure: ctrl_ready low 5 cycles during PIX_BYTES=1 burst -> ctrl_en/addr/wdat held, udp_source_ready low, no bytes lost, write count equals pixel count.
- COMMIT 03 on port 0x6603 -> ctrl_swap=6'b000011 for exactly 1 cycle, no writes; port 0x6503 -> nothing, counters unchanged.
- Runt 01 12 34 AA (last) -> no write, err_count=1; error on byte 3 of 6 -> no write, DRAIN to last, err_count+1.
- Reset asserted with write pending and ctrl_ready low -> ctrl_en 0 next cycle, counters 0, subsequent packet decoded normally.
